fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_unit_queue.sv | 57 +++++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: epoch width, queue entry layouts and
// the small address helper used when loading the PC.
package fetch_unit_pkg;

  localparam int EPOCH_W = 3;

  // One fetched instruction as handed to decode
  typedef struct packed {
    logic [31:0]        inst;
    logic [31:0]        pc;
    logic [EPOCH_W-1:0] epoch;
    logic               pred_taken;
    logic [31:0]        pred_target;
  } fetch_entry_t;

  // Bookkeeping for a request whose memory response has not yet returned
  typedef struct packed {
    logic [31:0]        pc;
    logic [EPOCH_W-1:0] epoch;
    logic               pred_taken;
    logic [31:0]        pred_target;
  } fetch_tag_t;

  // Clears the byte-offset bits so every fetch address is word aligned
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Generic synchronous FIFO with flush and occupancy count. Used both for
// the in-flight request tags and for the decoded-instruction fetch queue.
module fetch_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy tracking; a flush empties the queue in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Entry storage; contents need no reset because occupancy gates their use
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned requests steered by the
// branch predictor, matches in-order memory responses to their request tags,
// drops responses from a stale epoch, and buffers the rest for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4,
  parameter int          EPOCH_W  = fetch_unit_pkg::EPOCH_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [31:0]        imem_resp_data,
  output logic [31:0]        bp_pc,
  input  logic               bp_pred_taken,
  input  logic [31:0]        bp_pred_target,
  output logic               fetch_valid,
  output logic [31:0]        fetch_inst,
  output logic [31:0]        fetch_pc,
  output logic [EPOCH_W-1:0] fetch_epoch,
  output logic               pred_taken,
  output logic [31:0]        pred_target,
  input  logic               fetch_ready
);

  import fetch_unit_pkg::*;

  localparam int CW      = $clog2(FQ_DEPTH) + 1;
  localparam int TAG_W   = $bits(fetch_tag_t);
  localparam int ENTRY_W = $bits(fetch_entry_t);

  logic [31:0]        pc;
  logic [EPOCH_W-1:0] epoch;

  fetch_tag_t   tag_in;
  fetch_tag_t   tag_head;
  fetch_entry_t entry_in;
  fetch_entry_t entry_head;

  logic [CW-1:0] tag_count;
  logic [CW-1:0] fq_count;
  logic [CW:0]   credit_used;
  logic          tag_empty;
  logic          tag_full;
  logic          fq_empty;
  logic          fq_full;
  logic          req_fire;
  logic          resp_pop;
  logic          resp_keep;
  logic          fq_pop;

  // Requests in flight plus queued entries never exceed the queue depth, so
  // every response is guaranteed a slot without backpressuring memory
  assign credit_used    = {1'b0, tag_count} + {1'b0, fq_count};
  assign imem_req_valid = rst_n && !redirect_valid &&
                          (credit_used < (CW+1)'(FQ_DEPTH));
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = pc;
  assign bp_pc          = pc;

  assign tag_in.pc          = pc;
  assign tag_in.epoch       = epoch;
  assign tag_in.pred_taken  = bp_pred_taken;
  assign tag_in.pred_target = bp_pred_target;

  assign resp_pop  = imem_resp_valid && !tag_empty;
  assign resp_keep = resp_pop && (tag_head.epoch == epoch) && !redirect_valid;

  assign entry_in.inst        = imem_resp_data;
  assign entry_in.pc          = tag_head.pc;
  assign entry_in.epoch       = tag_head.epoch;
  assign entry_in.pred_taken  = tag_head.pred_taken;
  assign entry_in.pred_target = tag_head.pred_target;

  assign fetch_valid = rst_n && !fq_empty && !redirect_valid;
  assign fq_pop      = fetch_valid && fetch_ready;

  // PC and epoch: a redirect restarts fetch in a new epoch, otherwise the
  // PC follows the predictor on each accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      epoch <= '0;
    end else if (redirect_valid) begin
      pc    <= word_align(redirect_pc);
      epoch <= epoch + EPOCH_W'(1);
    end else if (req_fire) begin
      pc    <= bp_pred_taken ? word_align(bp_pred_target) : pc + 32'd4;
    end
  end

  // Decode-facing fields come from the queue head and read as zero in reset
  always_comb begin
    fetch_inst  = '0;
    fetch_pc    = '0;
    fetch_epoch = '0;
    pred_taken  = 1'b0;
    pred_target = '0;
    if (rst_n) begin
      fetch_inst  = entry_head.inst;
      fetch_pc    = entry_head.pc;
      fetch_epoch = entry_head.epoch;
      pred_taken  = entry_head.pred_taken;
      pred_target = entry_head.pred_target;
    end
  end

  // Tags survive redirects so stale responses can still be matched and dropped
  fetch_queue #(
    .WIDTH (TAG_W),
    .DEPTH (FQ_DEPTH)
  ) tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (tag_in),
    .pop       (resp_pop),
    .flush     (1'b0),
    .head_data (tag_head),
    .empty     (tag_empty),
    .full      (tag_full),
    .count     (tag_count)
  );

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (FQ_DEPTH)
  ) inst_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (resp_keep),
    .push_data (entry_in),
    .pop       (fq_pop),
    .flush     (redirect_valid),
    .head_data (entry_head),
    .empty     (fq_empty),
    .full      (fq_full),
    .count     (fq_count)
  );

  orphan_response: assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> !tag_empty);

  tag_credit: assert property (@(posedge clk) disable iff (!rst_n)
    !(req_fire && tag_full));

  queue_credit: assert property (@(posedge clk) disable iff (!rst_n)
    !(resp_keep && fq_full && !fq_pop));

endmodule
